mc_control_fsm: RTL and testbench

Multicycle main-control state machine for the processor datapath. It sequences each instruction through fetch, decode, execute, memory and writeback. Per state it drives the datapath select and enable lines, including CPSR update and reset and flag-conditional branches (beq/bvf/ben). It sits between the instruction register's opcode field and the shared multicycle datapath (PC, IR, register file, ALU, memory port, CPSR).

---
 rtl/mc_ctrl_pkg.sv | 62 ++++++
 rtl/mc_control_fsm_if.sv | 44 ++++
 rtl/mc_opdecode.sv | 34 +++
 rtl/mc_control_fsm.sv | 163 ++++++++++++++++
 tb/tb_mc_control_fsm.sv | 393 +++++++++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/mc_ctrl_pkg.sv
// Shared types and encodings for the multicycle main-control FSM.
package mc_ctrl_pkg;

    typedef enum logic [3:0] {
        FETCH    = 4'd0,
        DECODE   = 4'd1,
        MEMADR   = 4'd2,
        MEMRD    = 4'd3,
        MEMWB    = 4'd4,
        MEMWR    = 4'd5,
        RTYPE_EX = 4'd6,
        ALU_WB   = 4'd7,
        ADDI_EX  = 4'd8,
        ADDI_WB  = 4'd9,
        BRANCH   = 4'd10,
        JUMP     = 4'd11
    } state_t;

    localparam logic [5:0] OP_R    = 6'h00;
    localparam logic [5:0] OP_J    = 6'h02;
    localparam logic [5:0] OP_BEQ  = 6'h04;
    localparam logic [5:0] OP_BVF  = 6'h05;
    localparam logic [5:0] OP_BEN  = 6'h06;
    localparam logic [5:0] OP_ADDI = 6'h08;
    localparam logic [5:0] OP_LW   = 6'h23;
    localparam logic [5:0] OP_SW   = 6'h2B;

    localparam logic [1:0] ALUOP_ADD   = 2'b00;
    localparam logic [1:0] ALUOP_SUB   = 2'b01;
    localparam logic [1:0] ALUOP_FUNCT = 2'b10;

    localparam logic [1:0] SRCB_REG    = 2'b00;
    localparam logic [1:0] SRCB_FOUR   = 2'b01;
    localparam logic [1:0] SRCB_IMM    = 2'b10;
    localparam logic [1:0] SRCB_BRANCH = 2'b11;

    localparam logic [1:0] PCSRC_ALU    = 2'b00;
    localparam logic [1:0] PCSRC_ALUOUT = 2'b01;
    localparam logic [1:0] PCSRC_JUMP   = 2'b10;

    // One-hot instruction class produced by the opcode decoder.
    typedef struct packed {
        logic r;
        logic lw;
        logic sw;
        logic addi;
        logic beq;
        logic bvf;
        logic ben;
        logic j;
        logic illegal;
    } op_class_t;

    // Subset of the class kept after DECODE; only these bits steer later states.
    typedef struct packed {
        logic lw;
        logic beq;
        logic bvf;
        logic ben;
    } cls_latch_t;

endpackage

// File: rtl/mc_control_fsm_if.sv
// Control bus between the main-control FSM and the multicycle datapath.
interface mc_control_fsm_if #(
    parameter int unsigned OPW = 6
);
    logic [OPW-1:0] opcode;
    logic           mem_ready;
    logic           flag_z;
    logic           flag_v;
    logic           flag_n;

    logic           pc_write;
    logic           ir_write;
    logic           iord;
    logic           mem_read;
    logic           mem_write;
    logic           alusrca;
    logic [1:0]     alusrcb;
    logic [1:0]     aluop;
    logic [1:0]     pcsrc;
    logic           regdst;
    logic           memtoreg;
    logic           reg_write;
    logic           cpsr_update;
    logic           cpsr_reset;
    logic           instr_done;
    logic           illegal_op;
    logic [3:0]     state;

    // Controller side.
    modport master (
        input  opcode, mem_ready, flag_z, flag_v, flag_n,
        output pc_write, ir_write, iord, mem_read, mem_write, alusrca, alusrcb, aluop,
               pcsrc, regdst, memtoreg, reg_write, cpsr_update, cpsr_reset, instr_done,
               illegal_op, state
    );

    // Datapath side.
    modport slave (
        output opcode, mem_ready, flag_z, flag_v, flag_n,
        input  pc_write, ir_write, iord, mem_read, mem_write, alusrca, alusrcb, aluop,
               pcsrc, regdst, memtoreg, reg_write, cpsr_update, cpsr_reset, instr_done,
               illegal_op, state
    );
endinterface

// File: rtl/mc_opdecode.sv
// Combinational opcode-to-class decoder; upper opcode bits must be zero.
module mc_opdecode
    import mc_ctrl_pkg::*;
#(
    parameter int unsigned OPW     = 6,
    parameter bit          BFMT_EN = 1'b1
) (
    input  logic [OPW-1:0] opcode,
    output op_class_t      op_class
);

    // Exact-match decode; zero-extended constants reject nonzero upper bits.
    always_comb begin
        op_class = '0;
        case (opcode)
            OPW'(OP_R):    op_class.r    = 1'b1;
            OPW'(OP_J):    op_class.j    = 1'b1;
            OPW'(OP_BEQ):  op_class.beq  = 1'b1;
            OPW'(OP_BVF): begin
                if (BFMT_EN) op_class.bvf     = 1'b1;
                else         op_class.illegal = 1'b1;
            end
            OPW'(OP_BEN): begin
                if (BFMT_EN) op_class.ben     = 1'b1;
                else         op_class.illegal = 1'b1;
            end
            OPW'(OP_ADDI): op_class.addi = 1'b1;
            OPW'(OP_LW):   op_class.lw   = 1'b1;
            OPW'(OP_SW):   op_class.sw   = 1'b1;
            default:       op_class.illegal = 1'b1;
        endcase
    end

endmodule

// File: rtl/mc_control_fsm.sv
// Multicycle main-control FSM: sequences fetch/decode/execute/memory/writeback.
module mc_control_fsm
    import mc_ctrl_pkg::*;
#(
    parameter int unsigned OPW     = 6,
    parameter bit          BFMT_EN = 1'b1
) (
    input  logic             clk,
    input  logic             rst_n,
    mc_control_fsm_if.master bus
);

    state_t     state_q, state_d;
    cls_latch_t cls_q, cls_d;
    op_class_t  op_cls;
    // Low during reset and until the first edge after release, holding outputs at 0.
    logic       run_q;

    mc_opdecode #(
        .OPW     (OPW),
        .BFMT_EN (BFMT_EN)
    ) u_opdecode (
        .opcode   (bus.opcode),
        .op_class (op_cls)
    );

    // State, class latch and run flag registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= FETCH;
            cls_q   <= '0;
            run_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cls_q   <= cls_d;
            run_q   <= 1'b1;
        end
    end

    // Next-state logic; the opcode is consulted only in DECODE.
    always_comb begin
        state_d = state_q;
        cls_d   = cls_q;
        if (!run_q) begin
            state_d = FETCH;
        end else begin
            unique case (state_q)
                FETCH:    if (bus.mem_ready) state_d = DECODE;
                DECODE: begin
                    cls_d.lw  = op_cls.lw;
                    cls_d.beq = op_cls.beq;
                    cls_d.bvf = op_cls.bvf;
                    cls_d.ben = op_cls.ben;
                    if (op_cls.lw || op_cls.sw)                      state_d = MEMADR;
                    else if (op_cls.r)                               state_d = RTYPE_EX;
                    else if (op_cls.addi)                            state_d = ADDI_EX;
                    else if (op_cls.beq || op_cls.bvf || op_cls.ben) state_d = BRANCH;
                    else if (op_cls.j)                               state_d = JUMP;
                    else                                             state_d = FETCH;
                end
                MEMADR:   state_d = cls_q.lw ? MEMRD : MEMWR;
                MEMRD:    if (bus.mem_ready) state_d = MEMWB;
                MEMWB:    state_d = FETCH;
                MEMWR:    if (bus.mem_ready) state_d = FETCH;
                RTYPE_EX: state_d = ALU_WB;
                ALU_WB:   state_d = FETCH;
                ADDI_EX:  state_d = ADDI_WB;
                ADDI_WB:  state_d = FETCH;
                BRANCH:   state_d = FETCH;
                JUMP:     state_d = FETCH;
                default:  state_d = FETCH;
            endcase
        end
    end

    // Output decode from the state register, plus mem_ready/flag terms where needed.
    always_comb begin
        bus.pc_write    = 1'b0;
        bus.ir_write    = 1'b0;
        bus.iord        = 1'b0;
        bus.mem_read    = 1'b0;
        bus.mem_write   = 1'b0;
        bus.alusrca     = 1'b0;
        bus.alusrcb     = SRCB_REG;
        bus.aluop       = ALUOP_ADD;
        bus.pcsrc       = PCSRC_ALU;
        bus.regdst      = 1'b0;
        bus.memtoreg    = 1'b0;
        bus.reg_write   = 1'b0;
        bus.cpsr_update = 1'b0;
        bus.cpsr_reset  = 1'b0;
        bus.instr_done  = 1'b0;
        bus.illegal_op  = 1'b0;
        if (run_q) begin
            unique case (state_q)
                FETCH: begin
                    bus.mem_read = 1'b1;
                    bus.alusrcb  = SRCB_FOUR;
                    bus.pc_write = bus.mem_ready;
                    bus.ir_write = bus.mem_ready;
                end
                DECODE: begin
                    bus.alusrcb    = SRCB_BRANCH;
                    bus.illegal_op = op_cls.illegal;
                    bus.cpsr_reset = op_cls.illegal;
                    bus.instr_done = op_cls.illegal;
                end
                MEMADR, ADDI_EX: begin
                    bus.alusrca     = 1'b1;
                    bus.alusrcb     = SRCB_IMM;
                    bus.cpsr_update = 1'b1;
                end
                MEMRD: begin
                    bus.mem_read = 1'b1;
                    bus.iord     = 1'b1;
                end
                MEMWB: begin
                    bus.reg_write  = 1'b1;
                    bus.memtoreg   = 1'b1;
                    bus.instr_done = 1'b1;
                end
                MEMWR: begin
                    bus.mem_write  = 1'b1;
                    bus.iord       = 1'b1;
                    bus.instr_done = bus.mem_ready;
                end
                RTYPE_EX: begin
                    bus.alusrca     = 1'b1;
                    bus.aluop       = ALUOP_FUNCT;
                    bus.cpsr_update = 1'b1;
                end
                ALU_WB: begin
                    bus.reg_write  = 1'b1;
                    bus.regdst     = 1'b1;
                    bus.instr_done = 1'b1;
                end
                ADDI_WB: begin
                    bus.reg_write  = 1'b1;
                    bus.instr_done = 1'b1;
                end
                BRANCH: begin
                    bus.alusrca    = 1'b1;
                    bus.aluop      = ALUOP_SUB;
                    bus.pcsrc      = PCSRC_ALUOUT;
                    bus.cpsr_reset = 1'b1;
                    bus.instr_done = 1'b1;
                    bus.pc_write   = (cls_q.beq & bus.flag_z) | (cls_q.bvf & bus.flag_v) |
                                     (cls_q.ben & bus.flag_n);
                end
                JUMP: begin
                    bus.pcsrc      = PCSRC_JUMP;
                    bus.pc_write   = 1'b1;
                    bus.cpsr_reset = 1'b1;
                    bus.instr_done = 1'b1;
                end
                default: ;
            endcase
        end
    end

    assign bus.state = state_q;

endmodule

// File: tb/tb_mc_control_fsm.sv
// Scoreboard bench for mc_control_fsm: per-cycle expectations queued, then compared.
module tb_mc_control_fsm;
    import mc_ctrl_pkg::*;

    typedef struct packed {
        logic       pc_write;
        logic       ir_write;
        logic       iord;
        logic       mem_read;
        logic       mem_write;
        logic       alusrca;
        logic [1:0] alusrcb;
        logic [1:0] aluop;
        logic [1:0] pcsrc;
        logic       regdst;
        logic       memtoreg;
        logic       reg_write;
        logic       cpsr_update;
        logic       cpsr_reset;
        logic       instr_done;
        logic       illegal_op;
    } outs_t;

    typedef struct packed {
        logic       rst;
        logic       mr;
        logic [5:0] op;
        logic       z;
        logic       v;
        logic       n;
        logic [3:0] st;
        outs_t      o;
        logic [3:0] st1;
        outs_t      o1;
    } ent_t;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       mem_ready = 1'b0;
    logic       fz = 1'b0, fv = 1'b0, fn = 1'b0;
    logic [5:0] op = 6'h00;

    int    n_checks = 0;
    int    n_pass = 0;
    int    cyc = 0;
    string tname;
    ent_t  sb[$];
    ent_t  e;
    outs_t a, o;

    mc_control_fsm_if #(.OPW(6)) ifc0 ();
    mc_control_fsm_if #(.OPW(6)) ifc1 ();

    assign ifc0.opcode = op;
    assign ifc0.mem_ready = mem_ready;
    assign ifc0.flag_z = fz;
    assign ifc0.flag_v = fv;
    assign ifc0.flag_n = fn;
    assign ifc1.opcode = op;
    assign ifc1.mem_ready = mem_ready;
    assign ifc1.flag_z = fz;
    assign ifc1.flag_v = fv;
    assign ifc1.flag_n = fn;

    mc_control_fsm #(.OPW(6), .BFMT_EN(1'b1)) dut0 (.clk(clk), .rst_n(rst_n), .bus(ifc0));
    mc_control_fsm #(.OPW(6), .BFMT_EN(1'b0)) dut1 (.clk(clk), .rst_n(rst_n), .bus(ifc1));

    always #5 clk = ~clk;

    function automatic outs_t outs0();
        return '{ifc0.pc_write, ifc0.ir_write, ifc0.iord, ifc0.mem_read, ifc0.mem_write,
                 ifc0.alusrca, ifc0.alusrcb, ifc0.aluop, ifc0.pcsrc, ifc0.regdst,
                 ifc0.memtoreg, ifc0.reg_write, ifc0.cpsr_update, ifc0.cpsr_reset,
                 ifc0.instr_done, ifc0.illegal_op};
    endfunction

    function automatic outs_t outs1();
        return '{ifc1.pc_write, ifc1.ir_write, ifc1.iord, ifc1.mem_read, ifc1.mem_write,
                 ifc1.alusrca, ifc1.alusrcb, ifc1.aluop, ifc1.pcsrc, ifc1.regdst,
                 ifc1.memtoreg, ifc1.reg_write, ifc1.cpsr_update, ifc1.cpsr_reset,
                 ifc1.instr_done, ifc1.illegal_op};
    endfunction

    // Fixed (input-independent) outputs of each state, written from the state table.
    function automatic outs_t base(state_t s);
        outs_t r = '0;
        case (s)
            FETCH:    begin r.mem_read = 1; r.alusrcb = 2'b01; end
            DECODE:   r.alusrcb = 2'b11;
            MEMADR:   begin r.alusrca = 1; r.alusrcb = 2'b10; r.cpsr_update = 1; end
            MEMRD:    begin r.mem_read = 1; r.iord = 1; end
            MEMWB:    begin r.reg_write = 1; r.memtoreg = 1; r.instr_done = 1; end
            MEMWR:    begin r.mem_write = 1; r.iord = 1; end
            RTYPE_EX: begin r.alusrca = 1; r.aluop = 2'b10; r.cpsr_update = 1; end
            ALU_WB:   begin r.reg_write = 1; r.regdst = 1; r.instr_done = 1; end
            ADDI_EX:  begin r.alusrca = 1; r.alusrcb = 2'b10; r.cpsr_update = 1; end
            ADDI_WB:  begin r.reg_write = 1; r.instr_done = 1; end
            BRANCH:   begin
                r.alusrca = 1; r.aluop = 2'b01; r.pcsrc = 2'b01;
                r.cpsr_reset = 1; r.instr_done = 1;
            end
            JUMP:     begin
                r.pcsrc = 2'b10; r.pc_write = 1; r.cpsr_reset = 1; r.instr_done = 1;
            end
            default:  r = '0;
        endcase
        return r;
    endfunction

    task automatic push(input logic rst, input logic mr, input logic [5:0] opc,
                        input logic z, input logic v, input logic n,
                        input state_t st, input outs_t exp);
        ent_t x;
        x = '{rst, mr, opc, z, v, n, st, exp, st, exp};
        sb.push_back(x);
    endtask

    // Override the BFMT_EN=0 instance's expectation on the most recent entry.
    task automatic push_alt(input state_t st1, input outs_t exp1);
        ent_t x;
        x = sb.pop_back();
        x.st1 = st1;
        x.o1 = exp1;
        sb.push_back(x);
    endtask

    task automatic push_fetch(input logic [5:0] opc);
        outs_t f = base(FETCH);
        f.pc_write = 1;
        f.ir_write = 1;
        push(1, 1, opc, 0, 0, 0, FETCH, f);
    endtask

    task automatic push_reset();
        push(0, 1, 6'h2B, 0, 0, 0, FETCH, '0);
        push(0, 1, 6'h00, 1, 1, 1, FETCH, '0);
        push(1, 1, 6'h23, 0, 0, 0, FETCH, '0);
    endtask

    task automatic drive(input ent_t x);
        rst_n = x.rst;
        mem_ready = x.mr;
        op = x.op;
        fz = x.z;
        fv = x.v;
        fn = x.n;
        @(negedge clk);
    endtask

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        tname = "reset";
        cyc = 0;
        push_reset();
        while (sb.size() != 0) begin
            e = sb.pop_front();
            drive(e);
            a = outs0();
            n_checks++;
            if (ifc0.state !== e.st)
                $display("FAIL %s c%0d state got %0d want %0d", tname, cyc, ifc0.state, e.st);
            else n_pass++;
            n_checks++;
            if (a !== e.o) $display("FAIL %s c%0d outs got %h want %h", tname, cyc, a, e.o);
            else n_pass++;
            cyc++;
            next_cycle();
        end
    endtask

    task automatic test_rtype();
        tname = "rtype";
        cyc = 0;
        push_reset();
        push_fetch(6'h3F);
        push(1, 1, 6'h00, 0, 0, 0, DECODE, base(DECODE));
        push(1, 1, 6'h2B, 0, 0, 0, RTYPE_EX, base(RTYPE_EX));
        push(1, 1, 6'h2B, 0, 0, 0, ALU_WB, base(ALU_WB));
        while (sb.size() != 0) begin
            e = sb.pop_front();
            drive(e);
            a = outs0();
            n_checks++;
            if (ifc0.state !== e.st)
                $display("FAIL %s c%0d state got %0d want %0d", tname, cyc, ifc0.state, e.st);
            else n_pass++;
            n_checks++;
            if (a !== e.o) $display("FAIL %s c%0d outs got %h want %h", tname, cyc, a, e.o);
            else n_pass++;
            cyc++;
            next_cycle();
        end
    endtask

    task automatic test_lw_wait();
        tname = "lw_wait";
        cyc = 0;
        push_reset();
        push_fetch(6'h23);
        push(1, 1, 6'h23, 0, 0, 0, DECODE, base(DECODE));
        // Opcode changes after DECODE must not redirect lw to the store path.
        push(1, 1, 6'h2B, 0, 0, 0, MEMADR, base(MEMADR));
        push(1, 0, 6'h2B, 0, 0, 0, MEMRD, base(MEMRD));
        push(1, 0, 6'h2B, 0, 0, 0, MEMRD, base(MEMRD));
        push(1, 1, 6'h2B, 0, 0, 0, MEMRD, base(MEMRD));
        push(1, 1, 6'h2B, 0, 0, 0, MEMWB, base(MEMWB));
        while (sb.size() != 0) begin
            e = sb.pop_front();
            drive(e);
            a = outs0();
            n_checks++;
            if (ifc0.state !== e.st)
                $display("FAIL %s c%0d state got %0d want %0d", tname, cyc, ifc0.state, e.st);
            else n_pass++;
            n_checks++;
            if (a !== e.o) $display("FAIL %s c%0d outs got %h want %h", tname, cyc, a, e.o);
            else n_pass++;
            cyc++;
            next_cycle();
        end
    endtask

    task automatic test_branch();
        tname = "branch";
        cyc = 0;
        push_reset();
        o = base(BRANCH);
        o.pc_write = 1;
        push_fetch(6'h05);
        push(1, 1, 6'h05, 0, 1, 0, DECODE, base(DECODE));
        push(1, 1, 6'h05, 0, 1, 0, BRANCH, o);
        push_fetch(6'h05);
        push(1, 1, 6'h05, 1, 0, 1, DECODE, base(DECODE));
        push(1, 1, 6'h05, 1, 0, 1, BRANCH, base(BRANCH));
        push_fetch(6'h04);
        push(1, 1, 6'h04, 1, 0, 0, DECODE, base(DECODE));
        push(1, 1, 6'h05, 1, 0, 0, BRANCH, o);
        while (sb.size() != 0) begin
            e = sb.pop_front();
            drive(e);
            a = outs0();
            n_checks++;
            if (ifc0.state !== e.st)
                $display("FAIL %s c%0d state got %0d want %0d", tname, cyc, ifc0.state, e.st);
            else n_pass++;
            n_checks++;
            if (a !== e.o) $display("FAIL %s c%0d outs got %h want %h", tname, cyc, a, e.o);
            else n_pass++;
            cyc++;
            next_cycle();
        end
    endtask

    task automatic test_illegal();
        outs_t ill, fo, bo;
        tname = "illegal";
        cyc = 0;
        ill = base(DECODE);
        ill.illegal_op = 1;
        ill.cpsr_reset = 1;
        ill.instr_done = 1;
        fo = base(FETCH);
        fo.pc_write = 1;
        fo.ir_write = 1;
        bo = base(BRANCH);
        bo.pc_write = 1;
        // ben: decoded by BFMT_EN=1, illegal for BFMT_EN=0.
        push_reset();
        push_fetch(6'h06);
        push(1, 1, 6'h06, 0, 0, 1, DECODE, base(DECODE));
        push_alt(DECODE, ill);
        push(1, 1, 6'h06, 0, 0, 1, BRANCH, bo);
        push_alt(FETCH, fo);
        // 0x3F is illegal for both builds.
        push_reset();
        push_fetch(6'h3F);
        push(1, 1, 6'h3F, 0, 0, 0, DECODE, ill);
        push(1, 1, 6'h3F, 0, 0, 0, FETCH, fo);
        while (sb.size() != 0) begin
            e = sb.pop_front();
            drive(e);
            a = outs0();
            n_checks++;
            if (ifc0.state !== e.st)
                $display("FAIL %s c%0d state got %0d want %0d", tname, cyc, ifc0.state, e.st);
            else n_pass++;
            n_checks++;
            if (a !== e.o) $display("FAIL %s c%0d outs got %h want %h", tname, cyc, a, e.o);
            else n_pass++;
            a = outs1();
            n_checks++;
            if (ifc1.state !== e.st1)
                $display("FAIL %s nobfmt c%0d state got %0d want %0d",
                         tname, cyc, ifc1.state, e.st1);
            else n_pass++;
            n_checks++;
            if (a !== e.o1)
                $display("FAIL %s nobfmt c%0d outs got %h want %h", tname, cyc, a, e.o1);
            else n_pass++;
            cyc++;
            next_cycle();
        end
    endtask

    task automatic test_sw_reset();
        outs_t wr;
        tname = "sw_reset";
        cyc = 0;
        push_reset();
        push_fetch(6'h2B);
        push(1, 1, 6'h2B, 0, 0, 0, DECODE, base(DECODE));
        push(1, 1, 6'h23, 0, 0, 0, MEMADR, base(MEMADR));
        push(1, 0, 6'h23, 0, 0, 0, MEMWR, base(MEMWR));
        // Reset dropped while waiting: state and every output clear within the cycle.
        push(0, 0, 6'h23, 0, 0, 0, FETCH, '0);
        push(0, 1, 6'h23, 0, 0, 0, FETCH, '0);
        push(1, 1, 6'h23, 0, 0, 0, FETCH, '0);
        push(1, 0, 6'h2B, 0, 0, 0, FETCH, base(FETCH));
        push_fetch(6'h2B);
        push(1, 1, 6'h2B, 0, 0, 0, DECODE, base(DECODE));
        push(1, 1, 6'h00, 0, 0, 0, MEMADR, base(MEMADR));
        wr = base(MEMWR);
        wr.instr_done = 1;
        push(1, 1, 6'h00, 0, 0, 0, MEMWR, wr);
        while (sb.size() != 0) begin
            e = sb.pop_front();
            drive(e);
            a = outs0();
            n_checks++;
            if (ifc0.state !== e.st)
                $display("FAIL %s c%0d state got %0d want %0d", tname, cyc, ifc0.state, e.st);
            else n_pass++;
            n_checks++;
            if (a !== e.o) $display("FAIL %s c%0d outs got %h want %h", tname, cyc, a, e.o);
            else n_pass++;
            cyc++;
            next_cycle();
        end
    endtask

    task automatic test_back_to_back();
        int dones;
        tname = "back_to_back";
        cyc = 0;
        dones = 0;
        push_reset();
        push_fetch(6'h02);
        push(1, 1, 6'h02, 0, 0, 0, DECODE, base(DECODE));
        push(1, 1, 6'h08, 0, 0, 0, JUMP, base(JUMP));
        push_fetch(6'h08);
        push(1, 1, 6'h08, 0, 0, 0, DECODE, base(DECODE));
        push(1, 1, 6'h02, 0, 0, 0, ADDI_EX, base(ADDI_EX));
        push(1, 1, 6'h02, 0, 0, 0, ADDI_WB, base(ADDI_WB));
        push(1, 0, 6'h02, 0, 0, 0, FETCH, base(FETCH));
        while (sb.size() != 0) begin
            e = sb.pop_front();
            drive(e);
            a = outs0();
            if (e.rst) dones += int'(ifc0.instr_done);
            n_checks++;
            if (ifc0.state !== e.st)
                $display("FAIL %s c%0d state got %0d want %0d", tname, cyc, ifc0.state, e.st);
            else n_pass++;
            n_checks++;
            if (a !== e.o) $display("FAIL %s c%0d outs got %h want %h", tname, cyc, a, e.o);
            else n_pass++;
            cyc++;
            next_cycle();
        end
        n_checks++;
        if (dones !== 2) $display("FAIL %s instr_done pulses got %0d want 2", tname, dones);
        else n_pass++;
    endtask

    initial begin
        rst_n = 1'b0;
        next_cycle();
        test_reset();
        test_rtype();
        test_lw_wait();
        test_branch();
        test_illegal();
        test_sw_reset();
        test_back_to_back();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
